// File: rtl/cache_refill_ctrl_pkg.sv
// Shared types and constants for the cache refill sequencer: state encoding,
// derived beat/offset widths and the line-alignment helper.
package cache_refill_ctrl_pkg;

  localparam int LINE_WD_DEF = 512;
  localparam int BEAT_WD_DEF = 32;
  localparam int ADDR_WD_DEF = 32;

  localparam int BEATS  = LINE_WD_DEF / BEAT_WD_DEF;
  localparam int OFS_WD = $clog2(LINE_WD_DEF / 8);
  localparam int CNT_WD = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_ADDR = 3'd1,
    WB_DATA = 3'd2,
    WB_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5,
    REFILL  = 3'd6,
    HOLD    = 3'd7
  } state_e;

  function automatic logic [ADDR_WD_DEF-1:0] line_align(input logic [ADDR_WD_DEF-1:0] addr);
    return {addr[ADDR_WD_DEF-1:OFS_WD], {OFS_WD{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_wb.sv
// Victim-line write-back shift register; loads a whole line and presents it
// lowest beat first on beat_out, shifting one beat per accepted write.
module refill_wb_shifter #(
  parameter int LINE_WD = 512,
  parameter int BEAT_WD = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [LINE_WD-1:0] line_in,
  input  logic               shift,
  output logic [BEAT_WD-1:0] beat_out
);

  logic [LINE_WD-1:0] line_buf_r;

  // Line buffer: load has priority over shift
  always_ff @(posedge clk) begin
    if (!rst) begin
      line_buf_r <= {LINE_WD{1'b0}};
    end else if (load) begin
      line_buf_r <= line_in;
    end else if (shift) begin
      line_buf_r <= {{BEAT_WD{1'b0}}, line_buf_r[LINE_WD-1:BEAT_WD]};
    end else begin
      line_buf_r <= line_buf_r;
    end
  end

  assign beat_out = line_buf_r[BEAT_WD-1:0];

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss sequencer: optional dirty-victim write burst, then line read burst
// and a one-cycle refresh. CACHE_REFILL_PERF_EN adds miss/write-back counters.
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int CACHELINE_WD = LINE_WD_DEF,
  parameter int BEAT_WD      = BEAT_WD_DEF,
  parameter int ADDR_WD      = ADDR_WD_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss,
  input  logic                    write_back,
  input  logic [ADDR_WD-1:0]      raddr,
  input  logic [ADDR_WD-1:0]      waddr,
  input  logic [CACHELINE_WD-1:0] cacheline_old,
  output logic                    refresh,
  output logic [CACHELINE_WD-1:0] cacheline_new,
  output logic                    busy,
  output logic                    rd_req,
  output logic [ADDR_WD-1:0]      rd_addr,
  input  logic                    rd_gnt,
  input  logic                    rd_valid,
  input  logic [BEAT_WD-1:0]      rd_data,
  output logic                    wr_req,
  output logic [ADDR_WD-1:0]      wr_addr,
  input  logic                    wr_gnt,
  output logic                    wr_valid,
  output logic [BEAT_WD-1:0]      wr_data,
  input  logic                    wr_ready,
  input  logic                    wr_bresp
`ifdef CACHE_REFILL_PERF_EN
  ,
  output logic [31:0]             perf_miss_cnt,
  output logic [31:0]             perf_wb_cnt
`endif
);

  state_e            state_r, state_nxt_s;
  logic [CNT_WD-1:0] cnt_r;
  logic              load_s, shift_s, beat_s, cnt_clr_s, last_s;

  // Next-state decode and datapath strobes
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    beat_s      = 1'b0;
    cnt_clr_s   = 1'b0;
    last_s      = (cnt_r == CNT_WD'(BEATS - 1));
    case (state_r)
      IDLE: begin
        if (miss) begin
          load_s      = 1'b1;
          state_nxt_s = write_back ? WB_ADDR : RD_ADDR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WB_ADDR: begin
        if (wr_gnt) begin
          cnt_clr_s   = 1'b1;
          state_nxt_s = WB_DATA;
        end else begin
          state_nxt_s = WB_ADDR;
        end
      end
      WB_DATA: begin
        shift_s = wr_ready;
        if (wr_ready && last_s) begin
          state_nxt_s = WB_RESP;
        end else begin
          state_nxt_s = WB_DATA;
        end
      end
      WB_RESP: begin
        if (wr_bresp) begin
          state_nxt_s = RD_ADDR;
        end else begin
          state_nxt_s = WB_RESP;
        end
      end
      RD_ADDR: begin
        if (rd_gnt) begin
          cnt_clr_s   = 1'b1;
          state_nxt_s = RD_DATA;
        end else begin
          state_nxt_s = RD_ADDR;
        end
      end
      RD_DATA: begin
        beat_s = rd_valid;
        if (rd_valid && last_s) begin
          state_nxt_s = REFILL;
        end else begin
          state_nxt_s = RD_DATA;
        end
      end
      REFILL:  state_nxt_s = HOLD;
      HOLD:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Beat counter shared by the write and read bursts; wraps after the last beat
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= {CNT_WD{1'b0}};
    end else if (cnt_clr_s) begin
      cnt_r <= {CNT_WD{1'b0}};
    end else if (shift_s || beat_s) begin
      cnt_r <= cnt_r + CNT_WD'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Burst addresses captured at miss acceptance
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_addr <= {ADDR_WD{1'b0}};
      wr_addr <= {ADDR_WD{1'b0}};
    end else if (load_s) begin
      rd_addr <= line_align(raddr);
      wr_addr <= line_align(waddr);
    end else begin
      rd_addr <= rd_addr;
      wr_addr <= wr_addr;
    end
  end

  // Control outputs registered from the next state so they track the state exactly
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy     <= 1'b0;
      rd_req   <= 1'b0;
      wr_req   <= 1'b0;
      wr_valid <= 1'b0;
      refresh  <= 1'b0;
    end else begin
      busy     <= (state_nxt_s != IDLE);
      rd_req   <= (state_nxt_s == RD_ADDR);
      wr_req   <= (state_nxt_s == WB_ADDR);
      wr_valid <= (state_nxt_s == WB_DATA);
      refresh  <= (state_nxt_s == REFILL);
    end
  end

  // Fill line assembly; keeps its contents between misses
  always_ff @(posedge clk) begin
    if (!rst) begin
      cacheline_new <= {CACHELINE_WD{1'b0}};
    end else if (beat_s) begin
      cacheline_new[cnt_r*BEAT_WD +: BEAT_WD] <= rd_data;
    end else begin
      cacheline_new <= cacheline_new;
    end
  end

  refill_wb_shifter #(
    .LINE_WD (CACHELINE_WD),
    .BEAT_WD (BEAT_WD)
  ) u_wb_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .line_in  (cacheline_old),
    .shift    (shift_s),
    .beat_out (wr_data)
  );

`ifdef CACHE_REFILL_PERF_EN
  // Saturating miss and write-back event counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_miss_cnt <= 32'd0;
      perf_wb_cnt   <= 32'd0;
    end else begin
      if (load_s && (perf_miss_cnt != 32'hFFFF_FFFF)) begin
        perf_miss_cnt <= perf_miss_cnt + 32'd1;
      end else begin
        perf_miss_cnt <= perf_miss_cnt;
      end
      if (load_s && write_back && (perf_wb_cnt != 32'hFFFF_FFFF)) begin
        perf_wb_cnt <= perf_wb_cnt + 32'd1;
      end else begin
        perf_wb_cnt <= perf_wb_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: bus slave behaviour plus a
// line-level reference model (expected beats, addresses, latency, ordering).
module tb_cache_refill_ctrl;

  localparam int NB = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         miss = 1'b0;
  logic         write_back = 1'b0;
  logic [31:0]  raddr = 32'd0;
  logic [31:0]  waddr = 32'd0;
  logic [511:0] cacheline_old = 512'd0;
  logic         refresh;
  logic [511:0] cacheline_new;
  logic         busy;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         rd_gnt = 1'b0;
  logic         rd_valid = 1'b0;
  logic [31:0]  rd_data = 32'd0;
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic         wr_gnt = 1'b0;
  logic         wr_valid;
  logic [31:0]  wr_data;
  logic         wr_ready = 1'b0;
  logic         wr_bresp = 1'b0;
`ifdef CACHE_REFILL_PERF_EN
  logic [31:0]  perf_miss_cnt;
  logic [31:0]  perf_wb_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int perf_m   = 0;
  int perf_w   = 0;

  cache_refill_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .miss          (miss),
    .write_back    (write_back),
    .raddr         (raddr),
    .waddr         (waddr),
    .cacheline_old (cacheline_old),
    .refresh       (refresh),
    .cacheline_new (cacheline_new),
    .busy          (busy),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_gnt        (rd_gnt),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_gnt        (wr_gnt),
    .wr_valid      (wr_valid),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .wr_bresp      (wr_bresp)
`ifdef CACHE_REFILL_PERF_EN
    ,
    .perf_miss_cnt (perf_miss_cnt),
    .perf_wb_cnt   (perf_wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {busy, refresh, rd_req, wr_req, wr_valid}, 512'd0);
    check({tag, "_line"}, cacheline_new, 512'd0);
    check({tag, "_addr"}, {rd_addr, wr_addr, wr_data}, 512'd0);
  endtask

  // One complete miss transaction, driven and checked at negedges.
  task automatic run_miss(input logic [31:0] ra, input logic [31:0] wa, input bit wb,
                          input bit gaps, input bit idx_data, input bit hold_miss,
                          input bit chk_lat, input int rst_beat);
    logic [31:0]  exp_wr [NB];
    logic [31:0]  exp_rd [NB];
    logic [511:0] exp_line;
    int beats = 0;
    int wr_idx = 0;
    int cyc = 1;
    int phase = 0;
    int bresp_wait = 0;
    bit rd_granted = 1'b0;
    bit wr_granted = 1'b0;
    bit bresp_done = 1'b0;
    bit rd_seen = 1'b0;
    bit wr_seen = 1'b0;
    bit ready_tgl = 1'b0;
    bit done = 1'b0;

    for (int i = 0; i < NB; i++) begin
      exp_wr[i] = idx_data ? (32'hA000_0000 + 32'(i)) : $urandom;
      exp_rd[i] = idx_data ? 32'(i) : $urandom;
      cacheline_old[i*32 +: 32] = exp_wr[i];
      exp_line[i*32 +: 32]      = exp_rd[i];
    end
    bresp_wait = gaps ? int'($urandom_range(1, 3)) : 0;
    raddr      = ra;
    waddr      = wa;
    write_back = wb;
    miss       = 1'b1;
    perf_m++;
    if (wb) perf_w++;

    while (!done) begin
      @(negedge clk);
      cyc++;
      rd_gnt   = 1'b0;
      wr_gnt   = 1'b0;
      rd_valid = 1'b0;
      rd_data  = 32'd0;
      wr_ready = 1'b0;
      wr_bresp = 1'b0;
      if (cyc > 400) begin
        check("timeout", 512'(cyc), 512'd400);
        miss = 1'b0;
        done = 1'b1;
      end else if (phase == 1) begin
        check("refresh_one_cycle", {511'd0, refresh}, 512'd0);
        check("hold_busy", {511'd0, busy}, 512'd1);
        check("hold_no_req", {510'd0, rd_req, wr_req}, 512'd0);
        phase = 2;
      end else if (phase == 2) begin
        check("idle_state", {busy, refresh, rd_req, wr_req, wr_valid}, 512'd0);
`ifdef CACHE_REFILL_PERF_EN
        check("perf_miss", perf_miss_cnt, 512'(perf_m));
        check("perf_wb", perf_wb_cnt, 512'(perf_w));
`endif
        done = 1'b1;
      end else if (rst_beat >= 0 && rd_granted && beats == rst_beat) begin
        rst  = 1'b0;
        miss = 1'b0;
        @(negedge clk);
        check_all_zero("mid_burst_reset");
        rst    = 1'b1;
        perf_m = 0;
        perf_w = 0;
        done   = 1'b1;
      end else begin
        // write channel slave
        if (wr_req && !wr_seen) begin
          wr_seen = 1'b1;
          check("wr_addr", wr_addr, wa & 32'hFFFF_FFC0);
        end
        if (wr_req && !wr_granted) begin
          wr_gnt = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
          if (wr_gnt) wr_granted = 1'b1;
        end
        if (wr_valid) begin
          if (wr_idx >= NB) begin
            check("wr_overrun", 512'(wr_idx), 512'(NB - 1));
          end else begin
            ready_tgl = ~ready_tgl;
            wr_ready  = gaps ? ready_tgl : 1'b1;
            if (wr_ready) begin
              check("wr_data", wr_data, exp_wr[wr_idx]);
              wr_idx++;
            end
          end
        end else if (wb && wr_idx == NB && !bresp_done) begin
          if (bresp_wait == 0) begin
            wr_bresp   = 1'b1;
            bresp_done = 1'b1;
          end else begin
            bresp_wait--;
          end
        end
        // read channel slave
        if (rd_req && !rd_seen) begin
          rd_seen = 1'b1;
          check("rd_addr", rd_addr, ra & 32'hFFFF_FFC0);
          check("rd_after_wb", {511'd0, bresp_done}, {511'd0, wb});
        end
        if (rd_granted && beats < NB) begin
          rd_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
          if (rd_valid) begin
            rd_data = exp_rd[beats];
            beats++;
          end
        end else if (rd_req && !rd_granted) begin
          if (gaps) begin
            rd_valid = 1'b1;
            rd_data  = 32'hDEAD_BEEF;
          end
          rd_gnt = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
          if (rd_gnt) rd_granted = 1'b1;
        end
        if (refresh) begin
          check("refresh_line", cacheline_new, exp_line);
          check("rd_beats", 512'(beats), 512'(NB));
          check("wr_beats", 512'(wr_idx), wb ? 512'(NB) : 512'd0);
          check("refill_busy", {511'd0, busy}, 512'd1);
          if (chk_lat) check("latency", 512'(cyc), 512'd19);
          if (!hold_miss) miss = 1'b0;
          phase = 1;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b1;
    @(negedge clk);

    // clean miss, zero-wait bus, index data
    run_miss(32'h1000_0044, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    // dirty miss, zero-wait bus
    run_miss(32'h1000_0100, 32'h2000_0080, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    // dirty miss with stalled write beats and gapped reads
    run_miss($urandom, $urandom, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    // reset during read beat 7, then a normal miss
    run_miss(32'h3000_0010, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7);
    run_miss(32'h3000_0020, 32'h4000_0040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    // miss held through REFILL and HOLD, then a back-to-back new miss
    run_miss(32'h5000_00C4, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1);
    run_miss(32'h5000_1008, 32'h6000_2000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    // randomized mix
    for (int k = 0; k < 6; k++) begin
      run_miss($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'b0, 1'b0, 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
